// File: rtl/muskbus_arb_pkg.sv
// muskbus_arb_pkg: arbiter state encoding and default sizing shared by the Muskbus arbiter files
package muskbus_arb_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_t;
  localparam int BEATS_DEFAULT = 8;
  localparam int TAG_W_DEFAULT = 13;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way round-robin picker; req_i requests, prio_i breaks ties, gnt_o one-hot or zero
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);
  always_comb gnt_o = &req_i ? (prio_i ? 2'b10 : 2'b01) : req_i;
endmodule

// File: rtl/muskbus_arbiter.sv
// muskbus_arbiter: shares one Muskbus master port between the I-fetch cache (0) and D-cache (1)
//  clk_i/reset_i           clock, synchronous active-high reset
//  m_req*_i / m_reqack_o   per-requester line request (address, tag) and capture pulse
//  m_resp*_o / m_respack_i response beats routed to the owner, data/tag broadcast
//  bus_req*_o / bus_reqack_i   registered bus request
//  bus_resp*_i / bus_respack_o bus response beats and acknowledge
//  MUSKBUS_ARB_PERF_EN adds perf_grants_o / perf_wait_cycles_o (2x32 saturating counters)
module muskbus_arbiter
  import muskbus_arb_pkg::*;
#(
  parameter int BEATS = BEATS_DEFAULT,
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [1:0]         m_reqcyc_i,
  input  logic [127:0]       m_req_i,
  input  logic [2*TAG_W-1:0] m_reqtag_i,
  output logic [1:0]         m_reqack_o,
  output logic [1:0]         m_respcyc_o,
  output logic [63:0]        m_resp_o,
  output logic [TAG_W-1:0]   m_resptag_o,
  input  logic [1:0]         m_respack_i,
  output logic               bus_reqcyc_o,
  output logic [63:0]        bus_req_o,
  output logic [TAG_W-1:0]   bus_reqtag_o,
  input  logic               bus_reqack_i,
  input  logic               bus_respcyc_i,
  input  logic [63:0]        bus_resp_i,
  input  logic [TAG_W-1:0]   bus_resptag_i,
  output logic               bus_respack_o
`ifdef MUSKBUS_ARB_PERF_EN
  ,
  output logic [63:0]        perf_grants_o,
  output logic [63:0]        perf_wait_cycles_o
`endif
);
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  arb_state_t state_q;
  logic prio_q;
  logic owner_q;
  logic bus_reqcyc_q;
  logic [CW-1:0] beat_cnt_q;
  logic [63:0] bus_req_q;
  logic [TAG_W-1:0] bus_reqtag_q;
  logic [1:0] gnt;
  logic win;
  logic in_resp;
  logic beat_acc;
  logic last_beat;
  rr_pick2 u_pick (
    .req_i (m_reqcyc_i),
    .prio_i(prio_q),
    .gnt_o (gnt)
  );
  always_comb begin
    win = gnt[1];
    in_resp = state_q == RESP;
    m_reqack_o = state_q == IDLE ? gnt : 2'b00;
    m_respcyc_o = in_resp ? {owner_q & bus_respcyc_i, ~owner_q & bus_respcyc_i} : 2'b00;
    bus_respack_o = in_resp & m_respack_i[owner_q];
    beat_acc = bus_respcyc_i & bus_respack_o;
    last_beat = beat_cnt_q == CW'(BEATS - 1);
  end
  assign m_resp_o = bus_resp_i;
  assign m_resptag_o = bus_resptag_i;
  assign bus_reqcyc_o = bus_reqcyc_q;
  assign bus_req_o = bus_req_q;
  assign bus_reqtag_o = bus_reqtag_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      owner_q <= 1'b0;
      beat_cnt_q <= '0;
      bus_reqcyc_q <= 1'b0;
      bus_req_q <= '0;
      bus_reqtag_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|gnt) begin
          owner_q <= win;
          bus_req_q <= win ? m_req_i[127:64] : m_req_i[63:0];
          bus_reqtag_q <= win ? m_reqtag_i[2*TAG_W-1:TAG_W] : m_reqtag_i[TAG_W-1:0];
          bus_reqcyc_q <= 1'b1;
          state_q <= REQ;
        end
        REQ: if (bus_reqack_i) begin
          bus_reqcyc_q <= 1'b0;
          state_q <= RESP;
        end
        RESP: if (beat_acc) begin
          beat_cnt_q <= last_beat ? '0 : beat_cnt_q + 1'b1;
          if (last_beat) begin
            prio_q <= ~owner_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef MUSKBUS_ARB_PERF_EN
  logic [1:0][31:0] grants_q;
  logic [1:0][31:0] waits_q;
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < 2; i++) begin
      if (reset_i) begin
        grants_q[i] <= '0;
        waits_q[i] <= '0;
      end else begin
        if (m_reqack_o[i] && grants_q[i] != '1) grants_q[i] <= grants_q[i] + 1'b1;
        if (m_reqcyc_i[i] && !m_reqack_o[i] && waits_q[i] != '1) waits_q[i] <= waits_q[i] + 1'b1;
      end
    end
  end
  assign perf_grants_o = grants_q;
  assign perf_wait_cycles_o = waits_q;
  final $display("muskbus_arbiter perf: grants %0d/%0d wait_cycles %0d/%0d",
                 grants_q[0], grants_q[1], waits_q[0], waits_q[1]);
`endif
endmodule
